wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Round-robin Wishbone B4 pipelined arbiter that shares one slave port between N_MASTERS requesters.
- Typical use: CPU data port and a debug/DMA master sharing the LED/peripheral slave.
- Grant is held for a whole bus cycle (CYC high) and released when the owner drops CYC.
- A watchdog aborts cycles whose slave stops responding, so one hung slave cannot lock out every master.

Parameters:
N_MASTERS, 2, number of requesting masters (2..8)
WB_BUS_WIDTH, 16, data width in bits (multiple of 8)
WB_ADDR_WIDTH, 32, address width
TIMEOUT, 16, cycles without ack/err/rty before abort (>=2)
localparam WB_SEL = WB_BUS_WIDTH/8; localparam IDX_W = max(1, clog2(N_MASTERS))

Ports:
wb_clk_i  input  1  bus clock; all logic on its rising edge
wb_reset_n_i  input  1  asynchronous active-low reset; deassertion is synchronised externally
m_cyc_i  input  N_MASTERS  per-master CYC
m_stb_i  input  N_MASTERS  per-master STB
m_we_i  input  N_MASTERS  per-master WE
m_sel_i  input  N_MASTERS*WB_SEL  per-master SEL, master k at bits [k*WB_SEL +: WB_SEL]
m_addr_i  input  N_MASTERS*WB_ADDR_WIDTH  per-master address, packed as for m_sel_i
m_data_i  input  N_MASTERS*WB_BUS_WIDTH  per-master write data, packed as for m_sel_i
m_data_o  output  WB_BUS_WIDTH  read data, broadcast to all masters
m_ack_o  output  N_MASTERS  per-master ACK
m_err_o  output  N_MASTERS  per-master ERR
m_rty_o  output  N_MASTERS  per-master RTY
m_stall_o  output  N_MASTERS  per-master STALL
s_cyc_o  output  1  slave CYC
s_stb_o  output  1  slave STB
s_we_o  output  1  slave WE
s_sel_o  output  WB_SEL  slave SEL
s_addr_o  output  WB_ADDR_WIDTH  slave address
s_data_o  output  WB_BUS_WIDTH  slave write data
s_data_i  input  WB_BUS_WIDTH  slave read data
s_ack_i  input  1  slave ACK
s_err_i  input  1  slave ERR
s_rty_i  input  1  slave RTY
s_stall_i  input  1  slave STALL
grant_o  output  IDX_W  index of the current owner; valid while busy_o=1
busy_o  output  1  1 in BUSY or ABORT

Behaviour:
- Reset (async, wb_reset_n_i=0):
  - state=IDLE, grant=0, rr_ptr=0, watchdog=0.
  - All s_* outputs 0; m_ack_o/m_err_o/m_rty_o=0; m_stall_o=all 1s; busy_o=0.
- States:
  - IDLE: arbitrate.
  - BUSY: owner connected to the slave.
  - ABORT: timeout recovery.
- IDLE:
  - If any m_cyc_i is set, grant the first asserted index searching upward from rr_ptr, wrapping modulo N_MASTERS.
  - Register grant and go to BUSY. One cycle of arbitration latency; s_cyc_o is first high in the following cycle.
  - rr_ptr <= grant+1, with wrap (N_MASTERS-1 wraps to 0).
- BUSY routing is combinational from the registered grant:
  - s_cyc_o = m_cyc_i[g]; s_stb/we/sel/addr/data_o driven from master g.
  - m_ack_o[g]=s_ack_i, m_err_o[g]=s_err_i, m_rty_o[g]=s_rty_i, m_stall_o[g]=s_stall_i.
  - Non-owners: ack/err/rty=0, stall=1.
  - m_data_o = s_data_i at all times.
- BUSY to IDLE: when m_cyc_i[g]=0. s_cyc_o falls in that same cycle. Re-arbitration happens in the next (IDLE) cycle, so there is exactly one dead cycle between owners.
- Watchdog (BUSY only):
  - Clears on any cycle where s_ack_i|s_err_i|s_rty_i is set, or where no transfer is outstanding.
  - Outstanding count increments on an accepted strobe (s_stb_o & !s_stall_i) and decrements on ack/err/rty. The count has width clog2(TIMEOUT+1) and saturates.
  - Otherwise increments while outstanding>0 or s_stb_o is held under stall.
  - On reaching TIMEOUT: for one cycle assert m_err_o[g]=1 (ignoring the slave) and force s_cyc_o=s_stb_o=0 from that cycle on; enter ABORT.
- ABORT:
  - s_cyc_o=0; m_stall_o[g]=1; responses to all masters=0.
  - Late slave ack/err/rty are discarded.
  - Go to IDLE when m_cyc_i[g]=0.
- Simultaneous events:
  - Owner drops CYC in the cycle the watchdog hits TIMEOUT: the drop wins. Go to IDLE, no err.
  - A new request arriving while BUSY waits; it is never pre-empted.
- Reset mid-cycle: every output returns to its reset value immediately (asynchronously); any in-flight transfer is lost.

Test Plan:
- Single master: m0 writes 0x00A5 to 0x000000A0 with slave acking next cycle -> s_cyc_o rises 1 cycle after m_cyc_i[0], s_data_o=0x00A5, m_ack_o[0] pulses 1 cycle, grant_o=0.
- Contention: m0 and m1 raise CYC in the same cycle after reset -> m0 granted first and m_stall_o[1]=1; after m0 drops CYC there is one IDLE cycle, then grant_o=1.
- Fairness: both masters request continuously for 6 back-to-back single-beat cycles -> grant sequence 0,1,0,1,0,1.
- Pipelined read: m1 issues 3 strobes, slave stalls beat 2 for 2 cycles and returns 0x0005,0x0006,0x0007 -> m_ack_o[1] pulses 3 times with matching m_data_o; m0 sees no ack.
- Timeout: slave never acks, TIMEOUT=16 -> m_err_o[0] pulses exactly on the 16th cycle after strobe acceptance, s_cyc_o=0 from then on, a late s_ack_i is ignored, IDLE follows after m0 drops CYC.
- Async reset asserted mid-BUSY -> s_cyc_o=0, busy_o=0, m_stall_o=all 1s with no clock edge; after release the next grant starts from index 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter sharing one slave between N masters.
// A watchdog aborts any bus cycle whose slave stops answering.
module wb_arbiter #(
  parameter int N_MASTERS     = 2,
  parameter int WB_BUS_WIDTH  = 16,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int TIMEOUT       = 16,
  localparam int WB_SEL = WB_BUS_WIDTH / 8,
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_reset_n_i,
  input  logic [N_MASTERS-1:0]               m_cyc_i,
  input  logic [N_MASTERS-1:0]               m_stb_i,
  input  logic [N_MASTERS-1:0]               m_we_i,
  input  logic [N_MASTERS*WB_SEL-1:0]        m_sel_i,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i,
  input  logic [N_MASTERS*WB_BUS_WIDTH-1:0]  m_data_i,
  output logic [WB_BUS_WIDTH-1:0]            m_data_o,
  output logic [N_MASTERS-1:0]               m_ack_o,
  output logic [N_MASTERS-1:0]               m_err_o,
  output logic [N_MASTERS-1:0]               m_rty_o,
  output logic [N_MASTERS-1:0]               m_stall_o,
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  output logic                               s_we_o,
  output logic [WB_SEL-1:0]                  s_sel_o,
  output logic [WB_ADDR_WIDTH-1:0]           s_addr_o,
  output logic [WB_BUS_WIDTH-1:0]            s_data_o,
  input  logic [WB_BUS_WIDTH-1:0]            s_data_i,
  input  logic                               s_ack_i,
  input  logic                               s_err_i,
  input  logic                               s_rty_i,
  input  logic                               s_stall_i,
  output logic [IDX_W-1:0]                   grant_o,
  output logic                               busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_wdog;
  logic [CNT_W-1:0] r_outst;

  logic                     w_own_cyc;
  logic                     w_own_stb;
  logic                     w_own_we;
  logic [WB_SEL-1:0]        w_own_sel;
  logic [WB_ADDR_WIDTH-1:0] w_own_addr;
  logic [WB_BUS_WIDTH-1:0]  w_own_data;

  logic             w_any_req;
  logic             w_found_hi;
  logic [IDX_W-1:0] w_pick_hi;
  logic [IDX_W-1:0] w_pick_lo;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_next_ptr;

  logic w_resp;
  logic w_accept;
  logic w_pending;
  logic w_hit;

  // Owner signals, selected by the registered grant
  always_comb begin
    w_own_cyc  = 1'b0;
    w_own_stb  = 1'b0;
    w_own_we   = 1'b0;
    w_own_sel  = '0;
    w_own_addr = '0;
    w_own_data = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (r_grant == IDX_W'(k)) begin
        w_own_cyc  = m_cyc_i[k];
        w_own_stb  = m_stb_i[k];
        w_own_we   = m_we_i[k];
        w_own_sel  = m_sel_i[k*WB_SEL +: WB_SEL];
        w_own_addr = m_addr_i[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        w_own_data = m_data_i[k*WB_BUS_WIDTH +: WB_BUS_WIDTH];
      end
    end
  end

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester
  always_comb begin
    w_found_hi = 1'b0;
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (m_cyc_i[k]) begin
        w_pick_lo = IDX_W'(k);
        if (IDX_W'(k) >= r_rr_ptr) begin
          w_pick_hi  = IDX_W'(k);
          w_found_hi = 1'b1;
        end
      end
    end
  end

  assign w_any_req  = |m_cyc_i;
  assign w_pick     = w_found_hi ? w_pick_hi : w_pick_lo;
  assign w_next_ptr = (w_pick == LAST_IDX) ? '0 : w_pick + IDX_W'(1);

  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  assign w_accept  = w_own_stb & ~s_stall_i;
  assign w_pending = (r_outst != '0) | (w_own_stb & s_stall_i);
  // The owner dropping CYC in the timeout cycle takes precedence over the abort
  assign w_hit     = (r_state == ST_BUSY) & w_own_cyc & ~w_resp & w_pending &
                     (r_wdog == WDOG_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_wdog   <= '0;
      r_outst  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wdog  <= '0;
          r_outst <= '0;
          if (w_any_req) begin
            r_grant  <= w_pick;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!w_own_cyc) begin
            r_state <= ST_IDLE;
          end else if (w_hit) begin
            r_state <= ST_ABORT;
          end else begin
            if (w_accept && !w_resp) begin
              if (r_outst != CNT_MAX) r_outst <= r_outst + CNT_W'(1);
            end else if (w_resp && !w_accept && (r_outst != '0)) begin
              r_outst <= r_outst - CNT_W'(1);
            end
            if (w_resp || !w_pending) begin
              r_wdog <= '0;
            end else if (r_wdog != CNT_MAX) begin
              r_wdog <= r_wdog + CNT_W'(1);
            end
          end
        end
        ST_ABORT: begin
          if (!w_own_cyc) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Slave and master-response routing; only BUSY connects the owner
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_addr_o  = '0;
    s_data_o  = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    m_stall_o = '1;
    if (r_state == ST_BUSY) begin
      s_cyc_o  = w_own_cyc & ~w_hit;
      s_stb_o  = w_own_stb & ~w_hit;
      s_we_o   = w_own_we;
      s_sel_o  = w_own_sel;
      s_addr_o = w_own_addr;
      s_data_o = w_own_data;
      for (int k = 0; k < N_MASTERS; k++) begin
        if (r_grant == IDX_W'(k)) begin
          m_ack_o[k]   = s_ack_i & ~w_hit;
          m_err_o[k]   = s_err_i | w_hit;
          m_rty_o[k]   = s_rty_i & ~w_hit;
          m_stall_o[k] = s_stall_i | w_hit;
        end
      end
    end
  end

  assign m_data_o = s_data_i;
  assign grant_o  = r_grant;
  assign busy_o   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single transfer, reset, contention/fairness,
// pipelined read with stall, watchdog abort and drop-versus-timeout race.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_cyc;
  logic [1:0]  m_stb;
  logic [1:0]  m_we;
  logic [3:0]  m_sel;
  logic [63:0] m_addr;
  logic [31:0] m_data;
  logic [15:0] m_data_o;
  logic [1:0]  m_ack_o;
  logic [1:0]  m_err_o;
  logic [1:0]  m_rty_o;
  logic [1:0]  m_stall_o;
  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [1:0]  s_sel_o;
  logic [31:0] s_addr_o;
  logic [15:0] s_data_o;
  logic [15:0] s_data_i;
  logic        s_ack_i;
  logic        s_err_i;
  logic        s_rty_i;
  logic        s_stall_i;
  logic [0:0]  grant_o;
  logic        busy_o;

  int          n_checks;
  int          n_errors;
  int          e;
  logic [1:0]  onehot;

  wb_arbiter #(
    .N_MASTERS    (2),
    .WB_BUS_WIDTH (16),
    .WB_ADDR_WIDTH(32),
    .TIMEOUT      (16)
  ) dut (
    .wb_clk_i    (clk),
    .wb_reset_n_i(rst_n),
    .m_cyc_i     (m_cyc),
    .m_stb_i     (m_stb),
    .m_we_i      (m_we),
    .m_sel_i     (m_sel),
    .m_addr_i    (m_addr),
    .m_data_i    (m_data),
    .m_data_o    (m_data_o),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .m_rty_o     (m_rty_o),
    .m_stall_o   (m_stall_o),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_we_o      (s_we_o),
    .s_sel_o     (s_sel_o),
    .s_addr_o    (s_addr_o),
    .s_data_o    (s_data_o),
    .s_data_i    (s_data_i),
    .s_ack_i     (s_ack_i),
    .s_err_i     (s_err_i),
    .s_rty_i     (s_rty_i),
    .s_stall_i   (s_stall_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    m_cyc     = '0;
    m_stb     = '0;
    m_we      = '0;
    m_sel     = '0;
    m_addr    = '0;
    m_data    = '0;
    s_data_i  = '0;
    s_ack_i   = 1'b0;
    s_err_i   = 1'b0;
    s_rty_i   = 1'b0;
    s_stall_i = 1'b0;

    #3;
    chk("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    chk("rst_s_stb", 64'(s_stb_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_stall", 64'(m_stall_o), 64'h3);
    chk("rst_resp", 64'({m_ack_o, m_err_o, m_rty_o}), 64'h0);
    chk("rst_grant", 64'(grant_o), 64'h0);
    #9 rst_n = 1'b1;

    // Single master write, slave acks the cycle after acceptance
    tick();
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_sel = 4'b0011;
    m_addr[31:0] = 32'h0000_00A0; m_data[15:0] = 16'h00A5;
    #1;
    chk("w1_latency_cyc", 64'(s_cyc_o), 64'h0);
    tick();
    chk("w1_s_cyc", 64'(s_cyc_o), 64'h1);
    chk("w1_s_stb", 64'(s_stb_o), 64'h1);
    chk("w1_s_we", 64'(s_we_o), 64'h1);
    chk("w1_s_sel", 64'(s_sel_o), 64'h3);
    chk("w1_s_addr", 64'(s_addr_o), 64'hA0);
    chk("w1_s_data", 64'(s_data_o), 64'hA5);
    chk("w1_grant", 64'(grant_o), 64'h0);
    chk("w1_busy", 64'(busy_o), 64'h1);
    chk("w1_stall", 64'(m_stall_o), 64'h2);
    tick();
    m_stb = 2'b00; s_ack_i = 1'b1;
    #1;
    chk("w1_ack", 64'(m_ack_o), 64'h1);
    tick();
    s_ack_i = 1'b0; m_cyc = 2'b00; m_we = 2'b00;
    #1;
    chk("w1_ack_off", 64'(m_ack_o), 64'h0);
    chk("w1_drop_cyc", 64'(s_cyc_o), 64'h0);
    tick();
    chk("w1_idle", 64'(busy_o), 64'h0);

    // Async reset while BUSY; rr pointer must restart at 0
    m_cyc = 2'b01;
    tick();
    chk("ar_busy", 64'(busy_o), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_s_cyc", 64'(s_cyc_o), 64'h0);
    chk("ar_busy0", 64'(busy_o), 64'h0);
    chk("ar_stall", 64'(m_stall_o), 64'h3);
    m_cyc = 2'b11;
    #2 rst_n = 1'b1;

    // Contention and fairness: alternate grants 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      e = i % 2;
      onehot = (e == 0) ? 2'b01 : 2'b10;
      tick();
      chk("fair_grant", 64'(grant_o), 64'(e));
      chk("fair_busy", 64'(busy_o), 64'h1);
      if (i == 0) chk("contend_stall", 64'(m_stall_o), 64'h2);
      m_stb = onehot;
      #1;
      chk("fair_s_stb", 64'(s_stb_o), 64'h1);
      tick();
      m_stb = 2'b00; s_ack_i = 1'b1;
      #1;
      chk("fair_ack", 64'(m_ack_o), 64'(onehot));
      tick();
      s_ack_i = 1'b0; m_cyc = m_cyc & ~onehot;
      #1;
      chk("fair_drop", 64'(s_cyc_o), 64'h0);
      tick();
      if (i < 4) m_cyc = m_cyc | onehot;
      chk("fair_dead_cycle", 64'(busy_o), 64'h0);
    end

    // Pipelined read by m1, beat 2 stalled for two cycles
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b00; m_sel = 4'b1100;
    m_addr[63:32] = 32'h0000_0100;
    tick();
    chk("rd_grant", 64'(grant_o), 64'h1);
    chk("rd_addr1", 64'(s_addr_o), 64'h100);
    tick();
    m_addr[63:32] = 32'h0000_0102; s_stall_i = 1'b1; s_ack_i = 1'b1; s_data_i = 16'h0005;
    #1;
    chk("rd_ack1", 64'(m_ack_o), 64'h2);
    chk("rd_data1", 64'(m_data_o), 64'h5);
    chk("rd_stall", 64'(m_stall_o), 64'h3);
    tick();
    s_ack_i = 1'b0;
    #1;
    chk("rd_noack", 64'(m_ack_o), 64'h0);
    tick();
    s_stall_i = 1'b0;
    #1;
    chk("rd_addr2", 64'(s_addr_o), 64'h102);
    chk("rd_stall_rel", 64'(m_stall_o), 64'h1);
    tick();
    m_addr[63:32] = 32'h0000_0104; s_ack_i = 1'b1; s_data_i = 16'h0006;
    #1;
    chk("rd_ack2", 64'(m_ack_o), 64'h2);
    chk("rd_data2", 64'(m_data_o), 64'h6);
    tick();
    m_stb = 2'b00; s_data_i = 16'h0007;
    #1;
    chk("rd_ack3", 64'(m_ack_o), 64'h2);
    chk("rd_data3", 64'(m_data_o), 64'h7);
    tick();
    s_ack_i = 1'b0; m_cyc = 2'b00;
    #1;
    chk("rd_ack_off", 64'(m_ack_o), 64'h0);
    tick();
    chk("rd_idle", 64'(busy_o), 64'h0);

    // Watchdog: slave never answers a single accepted strobe
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    tick();
    chk("to_accept", 64'(s_stb_o), 64'h1);
    for (int k = 2; k <= 16; k++) begin
      tick();
      m_stb = 2'b00;
      #1;
      chk("to_no_err", 64'(m_err_o), 64'h0);
      chk("to_cyc_held", 64'(s_cyc_o), 64'h1);
    end
    tick();
    chk("to_err", 64'(m_err_o), 64'h1);
    chk("to_cyc_forced", 64'(s_cyc_o), 64'h0);
    chk("to_stb_forced", 64'(s_stb_o), 64'h0);
    tick();
    s_ack_i = 1'b1;
    #1;
    chk("ab_late_ack", 64'(m_ack_o), 64'h0);
    chk("ab_err_once", 64'(m_err_o), 64'h0);
    chk("ab_s_cyc", 64'(s_cyc_o), 64'h0);
    chk("ab_busy", 64'(busy_o), 64'h1);
    chk("ab_stall", 64'(m_stall_o), 64'h3);
    tick();
    s_ack_i = 1'b0; m_cyc = 2'b00;
    #1;
    chk("ab_hold", 64'(busy_o), 64'h1);
    tick();
    chk("ab_idle", 64'(busy_o), 64'h0);

    // Owner drops CYC in the timeout cycle: drop wins, no error
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    chk("race_grant", 64'(grant_o), 64'h0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      m_stb = 2'b00;
    end
    tick();
    m_cyc = 2'b00;
    #1;
    chk("race_no_err", 64'(m_err_o), 64'h0);
    chk("race_s_cyc", 64'(s_cyc_o), 64'h0);
    tick();
    chk("race_idle", 64'(busy_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
